// File: rtl/axi4_partition_rd_flat.sv
// rtl/axi4_partition_rd_flat.sv - splits one AXI4 read burst into PSIZE-beat sub-bursts, streams data back contiguously
`timescale 1ns/1ps
module axi4_partition_rd_flat #(
    parameter int PSIZE     = 128,
    parameter int IDSIZE    = 4,
    parameter int ASIZE     = 32,
    parameter int DSIZE     = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              s_arvalid_i,
    output logic              s_arready_o,
    input  logic [ASIZE-1:0]  s_araddr_i,
    input  logic [7:0]        s_arlen_i,
    input  logic [IDSIZE-1:0] s_arid_i,

    output logic              s_rvalid_o,
    input  logic              s_rready_i,
    output logic [DSIZE-1:0]  s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic              s_rlast_o,
    output logic [IDSIZE-1:0] s_rid_o,

    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    output logic [ASIZE-1:0]  m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [IDSIZE-1:0] m_arid_o,

    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    input  logic [DSIZE-1:0]  m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rlast_i,
    input  logic [IDSIZE-1:0] m_rid_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_AR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    localparam logic [8:0]       PSIZE_W    = 9'(PSIZE);
    localparam logic [ASIZE-1:0] SUB_STRIDE = ASIZE'(PSIZE * ADDR_STEP);

    logic [1:0]        state_q, state_d;
    logic [8:0]        remain_q, remain_d;
    logic [ASIZE-1:0]  addr_q, addr_d;
    logic [IDSIZE-1:0] id_q, id_d;
    logic              final_q, final_d;
    logic [7:0]        m_arlen_q, m_arlen_d;
    logic              s_arready_q;
    logic              m_arvalid_q;
    logic [ASIZE-1:0]  m_araddr_q;
    logic [IDSIZE-1:0] m_arid_q;

    logic in_rd;
    logic s_ar_hs;
    logic m_ar_hs;
    logic m_rlast_hs;
    logic unused_rid;

    assign in_rd      = (state_q == ST_RD);
    assign s_ar_hs    = s_arvalid_i && s_arready_q;
    assign m_ar_hs    = m_arvalid_q && m_arready_i;
    assign m_rlast_hs = in_rd && m_rvalid_i && s_rready_i && m_rlast_i;
    assign unused_rid = ^m_rid_i;

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        addr_d    = addr_q;
        id_d      = id_q;
        final_d   = final_q;
        m_arlen_d = m_arlen_q;
        case (state_q)
            ST_IDLE: begin
                if (s_ar_hs) begin
                    remain_d = {1'b0, s_arlen_i} + 9'd1;
                    addr_d   = s_araddr_i;
                    id_d     = s_arid_i;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (remain_q > PSIZE_W) begin
                    m_arlen_d = 8'(PSIZE_W - 9'd1);
                    final_d   = 1'b0;
                end else begin
                    m_arlen_d = 8'(remain_q - 9'd1);
                    final_d   = 1'b1;
                end
                state_d = ST_AR;
            end
            ST_AR: begin
                if (m_ar_hs) begin
                    remain_d = remain_q - ({1'b0, m_arlen_q} + 9'd1);
                    addr_d   = addr_q + SUB_STRIDE;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                // m_rlast marks the sub-burst end; beats are not counted
                if (m_rlast_hs) begin
                    state_d = final_q ? ST_IDLE : ST_CALC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            remain_q    <= 9'd0;
            addr_q      <= '0;
            id_q        <= '0;
            final_q     <= 1'b0;
            m_arlen_q   <= 8'd0;
            s_arready_q <= 1'b0;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_arid_q    <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            final_q     <= final_d;
            m_arlen_q   <= m_arlen_d;
            s_arready_q <= (state_d == ST_IDLE);
            m_arvalid_q <= (state_d == ST_AR);
            // Address and ID are captured once on entry to AR and held until the handshake
            if (state_q == ST_CALC) begin
                m_araddr_q <= addr_q;
                m_arid_q   <= id_q;
            end
        end
    end

    assign s_arready_o = s_arready_q;
    assign m_arvalid_o = m_arvalid_q;
    assign m_araddr_o  = m_araddr_q;
    assign m_arlen_o   = m_arlen_q;
    assign m_arid_o    = m_arid_q;

    assign s_rvalid_o  = in_rd && m_rvalid_i;
    assign m_rready_o  = in_rd && s_rready_i;
    assign s_rdata_o   = m_rdata_i;
    assign s_rresp_o   = m_rresp_i;
    assign s_rid_o     = id_q;
    assign s_rlast_o   = in_rd && m_rlast_i && final_q;

endmodule

// File: tb/tb_axi4_partition_rd_flat.sv
// tb/tb_axi4_partition_rd_flat.sv - randomized scoreboard bench for axi4_partition_rd_flat
`timescale 1ns/1ps
module tb_axi4_partition_rd_flat;

    localparam int PSIZE = 128;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [3:0]  s_arid = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arid;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
    logic [3:0]  m_rid = 4'h9;

    axi4_partition_rd_flat dut (
        .clk_i(clk), .rst_i(rst),
        .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
        .s_arlen_i(s_arlen), .s_arid_i(s_arid),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata),
        .s_rresp_o(s_rresp), .s_rlast_o(s_rlast), .s_rid_o(s_rid),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
        .m_arlen_o(m_arlen), .m_arid_o(m_arid),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata),
        .m_rresp_i(m_rresp), .m_rlast_i(m_rlast), .m_rid_i(m_rid)
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return a[3:2] ^ a[5:4];
    endfunction

    ar_t   exp_ar[$];
    beat_t exp_beats[$];
    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream memory model: accepts ARs, returns beats addressed araddr + 4*beat
    ar_t         pend[$];
    ar_t         sl_p;
    logic        sl_ar_hs, sl_r_hs;
    logic [31:0] sl_cap_addr, sl_ba;
    logic [7:0]  sl_cap_len;
    logic        sl_active = 1'b0;
    logic [31:0] sl_addr = '0;
    logic [7:0]  sl_len = '0, sl_beat = '0;
    int          ar_hold = 0, ar_pct = 100, rv_pct = 100, rr_pct = 100;

    always begin
        @(negedge clk);
        sl_ar_hs    = m_arvalid && m_arready;
        sl_cap_addr = m_araddr;
        sl_cap_len  = m_arlen;
        sl_r_hs     = m_rvalid && m_rready;
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
            sl_active = 1'b0;
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            m_rlast   = 1'b0;
        end else begin
            if (sl_ar_hs) pend.push_back(ar_t'{sl_cap_addr, sl_cap_len, 4'd0});
            if (sl_r_hs) begin
                m_rvalid = 1'b0;
                if (sl_beat == sl_len) sl_active = 1'b0;
                else sl_beat = sl_beat + 8'd1;
            end
            if (!sl_active && pend.size() > 0) begin
                sl_p      = pend.pop_front();
                sl_addr   = sl_p.addr;
                sl_len    = sl_p.len;
                sl_beat   = 8'd0;
                sl_active = 1'b1;
            end
            if (ar_hold > 0) begin
                m_arready = 1'b0;
                if (m_arvalid) ar_hold--;
            end else begin
                m_arready = ($urandom_range(0, 99) < ar_pct);
            end
            if (sl_active && !m_rvalid) m_rvalid = ($urandom_range(0, 99) < rv_pct);
            if (m_rvalid) begin
                sl_ba   = sl_addr + 32'(sl_beat) * 32'd4;
                m_rdata = mem_data(sl_ba);
                m_rresp = mem_resp(sl_ba);
                m_rlast = (sl_beat == sl_len);
            end
        end
        s_rready = ($urandom_range(0, 99) < rr_pct);
    end

    bit          mon_en = 1'b0;
    bit          in_flight = 1'b0;
    int          ev_cyc = -100, final_cyc = -100, beats_rx = 0;
    logic        prev_arvalid = 1'b0, prev_arhs = 1'b0;
    logic [31:0] prev_araddr = '0;
    logic [7:0]  prev_arlen = '0;
    logic [3:0]  prev_arid = '0;
    ar_t         ea;
    beat_t       eb;

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_arready) chk(!in_flight, "arready_while_busy", 64'(s_arready), 64'd0);
            if (m_arvalid && !prev_arvalid)
                chk(cyc - ev_cyc == 2, "ar_latency", 64'(cyc - ev_cyc), 64'd2);
            if (prev_arvalid && !prev_arhs)
                chk({m_arvalid, m_araddr, m_arlen, m_arid} == {1'b1, prev_araddr, prev_arlen, prev_arid},
                    "ar_stable", {19'd0, m_arvalid, m_araddr, m_arlen, m_arid},
                    {19'd0, 1'b1, prev_araddr, prev_arlen, prev_arid});
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) begin
                    chk(1'b0, "unexpected_ar", 64'(m_araddr), 64'd0);
                end else begin
                    ea = exp_ar.pop_front();
                    chk({m_araddr, m_arlen, m_arid} == {ea.addr, ea.len, ea.id}, "ar_fields",
                        {20'd0, m_araddr, m_arlen, m_arid}, {20'd0, ea.addr, ea.len, ea.id});
                end
            end
            if (m_rvalid && s_rvalid)
                chk(m_rready == s_rready, "rready_mirror", 64'(m_rready), 64'(s_rready));
            if (s_rvalid && s_rready) begin
                beats_rx++;
                if (exp_beats.size() == 0) begin
                    chk(1'b0, "unexpected_beat", 64'(s_rdata), 64'd0);
                end else begin
                    eb = exp_beats.pop_front();
                    chk({s_rdata, s_rresp, s_rlast, s_rid} == {eb.data, eb.resp, eb.last, eb.id},
                        "r_beat", {25'd0, s_rdata, s_rresp, s_rlast, s_rid},
                        {25'd0, eb.data, eb.resp, eb.last, eb.id});
                end
                if (s_rlast) begin
                    final_cyc = cyc;
                    in_flight = 1'b0;
                end
            end
            if (m_rvalid && m_rready && m_rlast && !s_rlast) ev_cyc = cyc;
            if (cyc == final_cyc + 1) chk(s_arready, "arready_after_final", 64'(s_arready), 64'd1);
            if (s_arvalid && s_arready) begin
                ev_cyc    = cyc;
                in_flight = 1'b1;
            end
        end
        prev_arvalid = m_arvalid;
        prev_arhs    = m_arvalid && m_arready;
        prev_araddr  = m_araddr;
        prev_arlen   = m_arlen;
        prev_arid    = m_arid;
    end

    task automatic do_burst(input logic [31:0] addr, input int len,
                            input logic [3:0] id, input bit wait_done);
        int          remain, n;
        logic [31:0] a;
        bit          ok;
        remain = len + 1;
        a = addr;
        while (remain > 0) begin
            n = (remain < PSIZE) ? remain : PSIZE;
            exp_ar.push_back(ar_t'{a, 8'(n - 1), id});
            a = a + 32'(PSIZE * 4);
            remain -= n;
        end
        for (int k = 0; k <= len; k++) begin
            a = addr + 32'(k * 4);
            exp_beats.push_back(beat_t'{mem_data(a), mem_resp(a), (k == len), id});
        end
        beats_rx = 0;
        @(posedge clk);
        #1;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        s_arlen   = 8'(len);
        s_arid    = id;
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = s_arready;
        end
        chk(ok, "ar_accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        if (wait_done) begin
            ok = 1'b0;
            for (int t = 0; t < 6000 && !ok; t++) begin
                @(negedge clk);
                ok = (exp_beats.size() == 0);
            end
            chk(ok, "burst_timeout", 64'(exp_beats.size()), 64'd0);
            chk(beats_rx == len + 1, "beat_count", 64'(beats_rx), 64'(len + 1));
            chk(exp_ar.size() == 0, "ar_left_over", 64'(exp_ar.size()), 64'd0);
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({s_arready, m_arvalid, s_rvalid, m_rready} == 4'b0000, "reset_ctrl",
            {60'd0, s_arready, m_arvalid, s_rvalid, m_rready}, 64'd0);
        chk({m_araddr, m_arlen, m_arid} == 44'd0, "reset_ar_fields",
            {20'd0, m_araddr, m_arlen, m_arid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(s_arready, "arready_after_reset", 64'(s_arready), 64'd1);
        mon_en = 1'b1;

        do_burst(32'h0000_1000, 9, 4'h3, 1'b1);
        do_burst(32'h0000_0000, 255, 4'h5, 1'b1);
        do_burst(32'h2000_0040, 199, 4'hA, 1'b1);
        do_burst(32'h0000_3000, 127, 4'h1, 1'b1);

        ar_hold = 5;
        rr_pct = 50; rv_pct = 70; ar_pct = 60;
        do_burst(32'h0000_4000, 150, 4'h7, 1'b1);
        do_burst(32'hFFFF_FF00, 255, 4'hC, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rr_pct = $urandom_range(30, 100);
            rv_pct = $urandom_range(30, 100);
            ar_pct = $urandom_range(20, 100);
            if ($urandom_range(0, 3) == 0) ar_hold = $urandom_range(1, 6);
            do_burst($urandom & 32'hFFFF_FFFC, $urandom_range(0, 255), 4'($urandom), 1'b1);
        end

        rr_pct = 100; rv_pct = 100; ar_pct = 100;
        do_burst(32'h0000_5000, 255, 4'h6, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_ar.size() == 0) && (beats_rx >= 140);
        end
        chk(ok, "second_subburst_timeout", 64'(beats_rx), 64'd140);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        exp_ar.delete();
        exp_beats.delete();
        in_flight = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({s_rvalid, m_arvalid, m_rready} == 3'b000, "midreset_quiet",
            {61'd0, s_rvalid, m_arvalid, m_rready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(s_arready, "arready_after_midreset", 64'(s_arready), 64'd1);
        mon_en = 1'b1;
        do_burst(32'h0000_6000, 3, 4'h2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", n_total);
        $fatal(1);
    end

endmodule

// File: doc/axi4_partition_rd_flat.md
# axi4_partition_rd_flat

Read-side companion to the write partitioner. It accepts one AXI4 read burst of up to 256 beats from an upstream master. It splits the burst into sequential downstream sub-bursts of at most PSIZE beats and streams the returned read data back upstream as one contiguous burst. It sits between an upstream AXI4 read master and a memory or interconnect that limits burst length, and it keeps one sub-burst outstanding at a time.

## Interface
- PSIZE, 128, maximum beats per downstream sub-burst (1..256)
- IDSIZE, 4, AXI ID width (same up and down)
- ASIZE, 32, address width
- DSIZE, 32, read data width
- ADDR_STEP, 4, address increment per beat (bytes); a sub-burst advances the address by PSIZE*ADDR_STEP
- clock  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- s_arvalid/s_arready  in/out  1  upstream AR handshake
- s_araddr  in  ASIZE  upstream start address
- s_arlen  in  8  upstream burst length minus 1
- s_arid  in  IDSIZE  upstream ID
- s_rvalid/s_rready  out/in  1  upstream R handshake
- s_rdata  out  DSIZE  read data
- s_rresp  out  2  response, passed through per beat
- s_rlast  out  1  last beat of the upstream burst
- s_rid  out  IDSIZE  latched upstream ID
- m_arvalid/m_arready  out/in  1  downstream AR handshake
- m_araddr  out  ASIZE  sub-burst address
- m_arlen  out  8  sub-burst length minus 1
- m_arid  out  IDSIZE  equals latched upstream ID
- m_rvalid/m_rready  in/out  1  downstream R handshake
- m_rdata  in  DSIZE, m_rresp in 2, m_rlast in 1, m_rid in IDSIZE (m_rid ignored)

## Operation
- States: IDLE, CALC, AR, RD.
  - IDLE: s_arready=1. On s_arvalid&&s_arready, latch remain=s_arlen+1 (9 bits), addr=s_araddr, id=s_arid, then go to CALC.
  - CALC: register m_arlen=min(remain,PSIZE)-1 and final=(remain<=PSIZE), then go to AR.
  - AR: m_arvalid=1 with m_araddr, m_arlen and m_arid stable. On m_arready, remain-=m_arlen+1 and addr+=PSIZE*ADDR_STEP (wraps modulo 2^ASIZE), then go to RD.
  - RD: the R path is connected. On m_rvalid&&m_rready&&m_rlast: if final, go to IDLE; otherwise go to CALC.
- R path, combinational, active only in RD:
  - s_rvalid=m_rvalid.
  - m_rready=s_rready.
  - s_rdata=m_rdata and s_rresp=m_rresp.
  - s_rid=id.
  - s_rlast=m_rlast&&final.
- Outside RD: s_rvalid=0 and m_rready=0. Downstream R beats outside RD are not accepted.
- Downstream m_rlast is trusted as the sub-burst boundary; beats are not counted.
- s_arready, m_arvalid, m_araddr, m_arlen and m_arid are registers decoded from the next state.

## Timing
- Reset values:
  - s_arready=0, m_arvalid=0, m_araddr=0, m_arlen=0, m_arid=0.
  - State is IDLE, remain=0, final=0.
  - s_rvalid=0 and m_rready=0, because the state is not RD.
- s_arready rises in the first cycle after rst deasserts.
- If rst asserts mid-operation, all state is dropped on the next edge with no upstream completion. The bench must not expect an upstream rlast for an aborted burst.
- Latency, with upstream AR accepted at edge 0:
  - CALC in cycle 1.
  - m_arvalid=1 from cycle 2.
  - RD begins in the cycle after the m_arready handshake.
  - After a non-final m_rlast handshake, the next m_arvalid comes 2 cycles later (CALC, then AR).
  - After the final beat, s_arready=1 in the next cycle.
- s_arready stays 0 from acceptance until the final beat handshake, so only one upstream burst is in flight.
- m_arvalid holds until m_arready; m_araddr, m_arlen and m_arid must not change while m_arvalid=1.
- Data throughput in RD is one beat per cycle with zero added latency. Backpressure on either side stalls both sides in the same cycle.
- s_arlen=255 with PSIZE=256 gives remain=256, so remain needs 9 bits and no 8-bit overflow occurs.
- PSIZE=1 gives single-beat sub-bursts, each with m_arlen=0.

## Test plan
- Short burst (PSIZE=128): s_araddr=0x1000, s_arlen=9 -> one m_ar with addr 0x1000 and len 9. 10 beats pass through; s_rlast on beat 10 only; s_arready back to 1 the cycle after.
- Split burst: s_arlen=255, addr 0x0 -> m_ar (0x0, 127) then m_ar (0x200, 127). m_rlast on beat 128 is not seen on s_rlast; s_rlast appears on beat 256; s_rid equals s_arid on every beat.
- Uneven split: s_arlen=199 -> m_arlen 127 then 71, at addresses A and A+0x200. Exactly-PSIZE case: s_arlen=127 -> single m_ar with len 127.
- Backpressure:
  - Hold m_arready=0 for 5 cycles: m_arvalid, m_araddr and m_arlen stay stable.
  - Toggle s_rready randomly: m_rready mirrors it, and no beat is lost or duplicated (check against a data counter).
- Address wrap: ASIZE=32, s_araddr=0xFFFFFF00, s_arlen=255 -> second m_araddr=0x00000100.
- Reset mid-burst: assert rst during RD of the second sub-burst.
  - Next cycle: s_rvalid=0, m_arvalid=0, m_rready=0.
  - After release: s_arready=1 one cycle later, and a fresh s_arlen=3 burst completes normally.
